mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer in front of the shared RAM/UART memory controller. It accepts instruction-fetch requests from IF and load/store requests from MEM, and grants one requester at a time. It drives the controller's `need_to_work` / `work_done` handshake, returns read data to the granted requester, and raises a pipeline stall while any request is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 255: wait-cycle limit per transaction; used only with `MEM_ARB_TIMEOUT_EN`. Range 1..255.
- `clk` input 1: clock. All logic is rising-edge.
- `rst` input 1: reset, asynchronous, active-low.
- `if_req` input 1: fetch request. Held by IF until `if_ready`.
- `if_addr` input 16: fetch address.
- `if_ready` output 1: one-cycle pulse, fetch complete.
- `if_data` output 16: fetched word. Valid with `if_ready`, held until the next fetch completes.
- `d_req` input 1: data request. Held by MEM until `d_ready`.
- `d_wr` input 1: 1 = store, 0 = load.
- `d_addr` input 16: data address.
- `d_wdata` input 16: store data.
- `d_ready` output 1: one-cycle pulse, data access complete.
- `d_rdata` output 16: load result. Valid with `d_ready`, held until the next load completes.
- `stall` output 1: combinational; `(if_req & ~if_ready) | (d_req & ~d_ready)`.
- `need_to_work` output 1: start request to the memory controller.
- `mem_rd`, `mem_wr` outputs 1 each: command to the memory controller. Never both 1.
- `mem_addr`, `mem_value` outputs 16 each: address and write data to the memory controller.
- `work_done` input 1: controller status. 0 = busy; 1 = idle/done. It is 1 while the controller is idle.
- `result` input 16: controller read data. Valid when `work_done` rises.
- `timeout_err` output 1: sticky timeout flag.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP. Encoding is free.
- **IDLE**
  - Samples `if_req` and `d_req`.
  - If only one is high, that requester is granted.
  - If both are high, the requester not named in `last_grant` is granted.
  - `last_grant` resets to FETCH, so the first conflict goes to data.
  - On a grant, register the command: fetch gives addr=`if_addr`, rd=1; data gives addr=`d_addr`, value=`d_wdata`, wr=`d_wr`, rd=`~d_wr`. Update `last_grant`, then go to ISSUE.
- **ISSUE:** `need_to_work`=1 and the command is driven. Go to WAIT_BUSY.
- **WAIT_BUSY:** hold `need_to_work`=1 until `work_done` is sampled 0, then go to WAIT_DONE.
- **WAIT_DONE:** `need_to_work`=0, command still held. When `work_done` is sampled 1, capture `result` and go to RESP.
- **RESP**
  - Pulse the granted requester's ready.
  - On a load or fetch, update that requester's data register from the captured result.
  - Clear `mem_rd` and `mem_wr`.
  - Go to IDLE.
- **Stability:** `mem_addr`, `mem_value`, `mem_rd` and `mem_wr` are stable from ISSUE through WAIT_DONE.
- **Request dropped mid-transaction:** the transaction is not aborted and ready still pulses. Requesters must not do this.
- **Non-granted request:** remains pending and is granted at the next IDLE.
- **Reset values:** every output is 0, `last_grant`=FETCH, state=IDLE.
- **Reset mid-transaction:** return to IDLE immediately with no ready pulse. Re-issuing the request is the requester's responsibility.

## Timing
- A request seen in IDLE at edge N gives ISSUE in cycle N+1 and WAIT_BUSY from N+2.
- Minimum request-to-ready latency is 5 cycles: IDLE, ISSUE, WAIT_BUSY (one cycle), WAIT_DONE (one cycle), RESP. Ready pulses in cycle N+4.
- Back-to-back transactions are separated by one IDLE cycle.
- Both ready signals are never high in the same cycle.
- `stall` is combinational, so it goes low in the same cycle as the ready pulse.

## Configuration
- **Macro `MEM_ARB_TIMEOUT_EN` defined**
  - An 8-bit wait counter clears in ISSUE and increments in each WAIT_BUSY or WAIT_DONE cycle.
  - When it equals `TIMEOUT_CYCLES`, go to RESP with captured data 16'hFFFF and set `timeout_err`=1.
  - `timeout_err` stays high until reset.
- **Macro not defined:** WAIT states wait indefinitely, and `timeout_err` is tied to 0.

## Test plan
- **Fetch read:** `if_req`=1, `if_addr`=16'h0004; model holds `work_done` low for 2 cycles, `result`=16'h1234 → `mem_rd`=1, `mem_addr`=16'h0004, then a single `if_ready` pulse with `if_data`=16'h1234.
- **Store:** `d_req`=1, `d_wr`=1, `d_addr`=16'h8010, `d_wdata`=16'hBEEF → `mem_wr`=1 and `mem_value`=16'hBEEF stable until WAIT_DONE, `d_ready` pulse, `if_ready` stays 0.
- **Simultaneous request after reset:** fetch 16'h0010 and load 16'h8020 raised in the same cycle → data transaction first, fetch second, `stall`=1 until `if_ready`.
- **Alternation:** both requests held continuously for 4 transactions → grant order D, F, D, F, one IDLE cycle between transactions.
- **Timeout:** with the macro, `TIMEOUT_CYCLES`=8, model never raises `work_done` → ready pulses after 8 wait cycles with data 16'hFFFF, `timeout_err`=1 until reset. Without the macro, no ready pulse in 100 cycles.
- **Reset mid-transaction:** assert `rst`=0 in WAIT_DONE → all outputs 0 asynchronously, no ready pulse. After release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer in front of the shared
// RAM/UART memory controller. Grants instruction fetch (IF) or load/store
// (MEM) one at a time, runs the controller's need_to_work/work_done
// handshake, returns read data and raises a combinational pipeline stall.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request, held until if_ready
//   if_ready/if_data         fetch complete pulse, fetched word (held)
//   d_req/d_wr/d_addr/d_wdata data request (d_wr=1 store), held until d_ready
//   d_ready/d_rdata          data complete pulse, load result (held)
//   stall                    outstanding request not yet completing
//   need_to_work             start request to the memory controller
//   mem_rd/mem_wr/mem_addr/mem_value  command to the memory controller
//   work_done/result         controller idle/done flag, read data
//   timeout_err              sticky wait timeout flag
//
// Build option: define MEM_ARB_TIMEOUT_EN to bound each wait by
// TIMEOUT_CYCLES cycles; otherwise waits are unbounded and timeout_err is 0.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic [15:0] if_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic        stall,
  output logic        need_to_work,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_value,
  input  logic        work_done,
  input  logic [15:0] result,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP
  } state_t;

  typedef enum logic {
    G_FETCH = 1'b0,
    G_DATA  = 1'b1
  } grant_t;

  state_t      r_state, w_next_state;
  grant_t      r_grant, r_last_grant, w_pick;
  logic [15:0] r_mem_addr, r_mem_value, r_if_data, r_d_rdata;
  logic        r_mem_rd, r_mem_wr;
  logic        w_to_resp, w_expired, w_timeout, w_waiting;
  logic [15:0] w_resp_data;

  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

  // On a conflict the requester not served last time wins.
  assign w_pick = (d_req && (!if_req || (r_last_grant == G_FETCH))) ? G_DATA : G_FETCH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_to_resp    = 1'b0;
    w_expired    = 1'b0;
    case (r_state)
      S_IDLE:      if (if_req || d_req) w_next_state = S_ISSUE;
      S_ISSUE:     w_next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_timeout) begin
          w_next_state = S_RESP;
          w_to_resp    = 1'b1;
          w_expired    = 1'b1;
        end else if (!work_done) begin
          w_next_state = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A real completion on the last allowed cycle beats the timeout.
        if (work_done) begin
          w_next_state = S_RESP;
          w_to_resp    = 1'b1;
        end else if (w_timeout) begin
          w_next_state = S_RESP;
          w_to_resp    = 1'b1;
          w_expired    = 1'b1;
        end
      end
      S_RESP:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  assign w_resp_data = w_expired ? 16'hFFFF : result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant      <= G_FETCH;
      r_last_grant <= G_FETCH;
      r_mem_addr   <= '0;
      r_mem_value  <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_if_data    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if ((r_state == S_IDLE) && (if_req || d_req)) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        if (w_pick == G_DATA) begin
          r_mem_addr  <= d_addr;
          r_mem_value <= d_wdata;
          r_mem_wr    <= d_wr;
          r_mem_rd    <= ~d_wr;
        end else begin
          r_mem_addr  <= if_addr;
          r_mem_rd    <= 1'b1;
          r_mem_wr    <= 1'b0;
        end
      end
      // Result is written on entry to RESP so the data register is already
      // valid while the ready pulse is high.
      if (w_to_resp) begin
        if (r_grant == G_FETCH) r_if_data <= w_resp_data;
        else if (r_mem_rd)      r_d_rdata <= w_resp_data;
      end
      if (r_state == S_RESP) begin
        r_mem_rd <= 1'b0;
        r_mem_wr <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_LIMIT = TIMEOUT_CYCLES[7:0];

  logic [7:0] r_wait_cnt;
  logic [7:0] w_cnt_next;
  logic       r_timeout_err;

  assign w_cnt_next = r_wait_cnt + 8'd1;
  assign w_timeout  = w_waiting && (w_cnt_next == LP_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) r_wait_cnt <= '0;
      else if (w_waiting)     r_wait_cnt <= w_cnt_next;
      if (w_expired) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign need_to_work = (r_state == S_ISSUE) || (r_state == S_WAIT_BUSY);
  assign if_ready     = (r_state == S_RESP) && (r_grant == G_FETCH);
  assign d_ready      = (r_state == S_RESP) && (r_grant == G_DATA);
  assign if_data      = r_if_data;
  assign d_rdata      = r_d_rdata;
  assign mem_addr     = r_mem_addr;
  assign mem_value    = r_mem_value;
  assign mem_rd       = r_mem_rd;
  assign mem_wr       = r_mem_wr;
  assign stall        = (if_req && !if_ready) || (d_req && !d_ready);

endmodule
